// File: rtl/lsu_dcache_port.sv
// lsu_dcache_port: memory-stage load/store port between EX and the Dcache.
// Define LSU_MISALIGN_EXC_EN to flag misaligned accesses instead of truncating them.
module lsu_dcache_port #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_mem_req_i,
  input  logic          ex_mem_rw_i,
  input  logic [1:0]    ex_mem_width_i,
  input  logic          ex_mem_rdtype_i,
  input  logic [AW-1:0] ex_mem_addr_i,
  input  logic [31:0]   ex_mem_wr_data_i,
  input  logic [4:0]    ex_reg_waddr_i,
  input  logic          ex_reg_we_i,
  output logic          dc_req_o,
  output logic          dc_we_o,
  output logic [AW-1:0] dc_addr_o,
  output logic [3:0]    dc_be_o,
  output logic [31:0]   dc_wdata_o,
  input  logic          dc_ready_i,
  input  logic          dc_rvalid_i,
  input  logic [31:0]   dc_rdata_i,
  output logic [31:0]   mem_rdata_o,
  output logic          mem_rvalid_o,
  output logic [4:0]    mem_reg_waddr_o,
  output logic          mem_reg_we_o,
  output logic          mem_misalign_o,
  output logic          lsu_bk_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state;
  logic [1:0] width_q, off_q, o;
  logic rdtype_q, we_q, start, mis;
  logic [3:0] be;
  logic [31:0] wdata, ext;
  logic [7:0] b;
  logic [15:0] h;
  assign o = ex_mem_addr_i[1:0];
  assign start = (state == IDLE) & ex_mem_req_i;
  assign mis = (ex_mem_width_i == 2'b01 & o[0]) | (ex_mem_width_i[1] & o != 2'b00);
  always_comb begin
    be = ex_mem_width_i == 2'b00 ? 4'b0001 << o :
         ex_mem_width_i == 2'b01 ? 4'b0011 << {o[1], 1'b0} : 4'b1111;
    wdata = ex_mem_width_i == 2'b00 ? {4{ex_mem_wr_data_i[7:0]}} :
            ex_mem_width_i == 2'b01 ? {2{ex_mem_wr_data_i[15:0]}} : ex_mem_wr_data_i;
    b = dc_rdata_i[{off_q, 3'b000} +: 8];
    h = dc_rdata_i[{off_q[1], 4'b0000} +: 16];
    ext = width_q == 2'b00 ? {{24{~rdtype_q & b[7]}}, b} :
          width_q == 2'b01 ? {{16{~rdtype_q & h[15]}}, h} : dc_rdata_i;
  end
  assign dc_req_o = state == REQ;
  assign mem_rvalid_o = state == RESP;
  assign lsu_bk_o = start | state == REQ | state == WAIT;
`ifdef LSU_MISALIGN_EXC_EN
  logic mis_q;
  assign mem_misalign_o = mem_rvalid_o & mis_q;
  assign mem_reg_we_o = mem_rvalid_o & we_q & ~dc_we_o & ~mis_q;
`else
  logic mis_q;
  assign mem_misalign_o = 1'b0;
  assign mem_reg_we_o = mem_rvalid_o & we_q & ~dc_we_o;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dc_we_o <= 1'b0;
      dc_addr_o <= '0;
      dc_be_o <= '0;
      dc_wdata_o <= '0;
      width_q <= '0;
      off_q <= '0;
      rdtype_q <= 1'b0;
      we_q <= 1'b0;
      mis_q <= 1'b0;
      mem_reg_waddr_o <= '0;
      mem_rdata_o <= '0;
    end else begin
      case (state)
        IDLE: if (ex_mem_req_i) begin
          dc_we_o <= ex_mem_rw_i;
          dc_addr_o <= {ex_mem_addr_i[AW-1:2], 2'b00};
          dc_be_o <= be;
          dc_wdata_o <= wdata;
          width_q <= ex_mem_width_i;
          off_q <= o;
          rdtype_q <= ex_mem_rdtype_i;
          we_q <= ex_reg_we_i;
          mem_reg_waddr_o <= ex_reg_waddr_i;
          mem_rdata_o <= '0;
`ifdef LSU_MISALIGN_EXC_EN
          mis_q <= mis;
          state <= mis ? RESP : REQ;
`else
          mis_q <= 1'b0;
          state <= REQ;
`endif
        end
        REQ: if (dc_ready_i) begin
          if (!dc_we_o && dc_rvalid_i) mem_rdata_o <= ext;
          state <= (dc_we_o || dc_rvalid_i) ? RESP : WAIT;
        end
        WAIT: if (dc_rvalid_i) begin
          mem_rdata_o <= ext;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_dcache_port.sv
// tb_lsu_dcache_port: directed self-checking bench for lsu_dcache_port.
module tb_lsu_dcache_port;
  logic clk = 0, rst_n = 0;
  logic req = 0, rw = 0, rdtype = 0, reg_we = 0;
  logic [1:0] width = 0;
  logic [31:0] addr = 0, wr_data = 0;
  logic [4:0] reg_waddr = 0;
  logic dc_req, dc_we, dc_ready = 0, dc_rvalid = 0;
  logic [31:0] dc_addr, dc_wdata, dc_rdata = 0, mem_rdata;
  logic [3:0] dc_be;
  logic mem_rvalid, mem_reg_we, mem_misalign, lsu_bk;
  logic [4:0] mem_reg_waddr;
  int checks = 0, errors = 0;
  logic busy = 0;
  always #5 clk = ~clk;
  lsu_dcache_port #(.AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mem_req_i(req), .ex_mem_rw_i(rw), .ex_mem_width_i(width),
    .ex_mem_rdtype_i(rdtype), .ex_mem_addr_i(addr), .ex_mem_wr_data_i(wr_data),
    .ex_reg_waddr_i(reg_waddr), .ex_reg_we_i(reg_we),
    .dc_req_o(dc_req), .dc_we_o(dc_we), .dc_addr_o(dc_addr), .dc_be_o(dc_be),
    .dc_wdata_o(dc_wdata), .dc_ready_i(dc_ready), .dc_rvalid_i(dc_rvalid),
    .dc_rdata_i(dc_rdata), .mem_rdata_o(mem_rdata), .mem_rvalid_o(mem_rvalid),
    .mem_reg_waddr_o(mem_reg_waddr), .mem_reg_we_o(mem_reg_we),
    .mem_misalign_o(mem_misalign), .lsu_bk_o(lsu_bk)
  );
  // a new request may only arrive once the previous one has completed
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= 1'b0;
    else begin
      assert (!(req && busy)) else begin
        errors++;
        $error("FAIL protocol: request while access outstanding");
      end
      if (req) busy <= 1'b1;
      else if (mem_rvalid) busy <= 1'b0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic w, input logic [1:0] wd, input logic rt,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] ra);
    cyc();
    req = 1; rw = w; width = wd; rdtype = rt; addr = a; wr_data = d;
    reg_waddr = ra; reg_we = ~w;
    #1;
    chk("bk_capture", {31'b0, lsu_bk}, 1);
    cyc();
    req = 0; addr = 0; wr_data = 0;
  endtask
  initial begin
    #2;
    chk("rst_dc_req", {31'b0, dc_req}, 0);
    chk("rst_rvalid", {31'b0, mem_rvalid}, 0);
    chk("rst_bk", {31'b0, lsu_bk}, 0);
    chk("rst_be", {28'b0, dc_be}, 0);
    chk("rst_rdata", mem_rdata, 0);
    #10 rst_n = 1;
    // load byte signed, lane 3
    issue(0, 2'b00, 0, 32'h1003, 0, 5'd5);
    chk("lb_req", {31'b0, dc_req}, 1);
    chk("lb_be", {28'b0, dc_be}, 4'b1000);
    chk("lb_addr", dc_addr, 32'h1000);
    chk("lb_we", {31'b0, dc_we}, 0);
    dc_ready = 1; dc_rvalid = 1; dc_rdata = 32'h80FF_1234;
    cyc();
    dc_ready = 0; dc_rvalid = 0;
    chk("lb_rvalid", {31'b0, mem_rvalid}, 1);
    chk("lb_rdata", mem_rdata, 32'hFFFF_FF80);
    chk("lb_regwe", {31'b0, mem_reg_we}, 1);
    chk("lb_waddr", {27'b0, mem_reg_waddr}, 5);
    chk("lb_bk", {31'b0, lsu_bk}, 0);
    cyc();
    chk("lb_pulse_end", {31'b0, mem_rvalid}, 0);
    // store half, ready three cycles late
    issue(1, 2'b01, 0, 32'h2002, 32'hDEAD_BEEF, 5'd7);
    for (int i = 0; i < 3; i++) begin
      chk("sh_req_held", {31'b0, dc_req}, 1);
      chk("sh_bk_held", {31'b0, lsu_bk}, 1);
      chk("sh_no_rvalid", {31'b0, mem_rvalid}, 0);
      cyc();
    end
    dc_ready = 1;
    chk("sh_req", {31'b0, dc_req}, 1);
    chk("sh_wdata", dc_wdata, 32'hBEEF_BEEF);
    chk("sh_be", {28'b0, dc_be}, 4'b1100);
    chk("sh_we", {31'b0, dc_we}, 1);
    chk("sh_addr", dc_addr, 32'h2000);
    cyc();
    dc_ready = 0;
    chk("sh_rvalid", {31'b0, mem_rvalid}, 1);
    chk("sh_regwe", {31'b0, mem_reg_we}, 0);
    chk("sh_rdata", mem_rdata, 0);
    // load half unsigned, rvalid three cycles after acceptance
    issue(0, 2'b01, 1, 32'h0, 0, 5'd9);
    chk("lhu_be", {28'b0, dc_be}, 4'b0011);
    dc_ready = 1;
    cyc();
    dc_ready = 0;
    for (int i = 0; i < 2; i++) begin
      chk("lhu_wait_req", {31'b0, dc_req}, 0);
      chk("lhu_wait_bk", {31'b0, lsu_bk}, 1);
      chk("lhu_wait_rv", {31'b0, mem_rvalid}, 0);
      cyc();
    end
    dc_rvalid = 1; dc_rdata = 32'h1234_8001;
    chk("lhu_bk4", {31'b0, lsu_bk}, 1);
    cyc();
    dc_rvalid = 0;
    chk("lhu_rvalid", {31'b0, mem_rvalid}, 1);
    chk("lhu_rdata", mem_rdata, 32'h0000_8001);
    chk("lhu_bk5", {31'b0, lsu_bk}, 0);
    // load half signed, upper lane
    issue(0, 2'b01, 0, 32'h0006, 0, 5'd3);
    chk("lh_be", {28'b0, dc_be}, 4'b1100);
    dc_ready = 1; dc_rvalid = 1; dc_rdata = 32'h8001_0000;
    cyc();
    dc_ready = 0; dc_rvalid = 0;
    chk("lh_rdata", mem_rdata, 32'hFFFF_8001);
    // load word, minimum latency
    issue(0, 2'b10, 0, 32'h40, 0, 5'd1);
    dc_ready = 1; dc_rvalid = 1; dc_rdata = 32'hCAFE_F00D;
    cyc();
    dc_ready = 0; dc_rvalid = 0;
    chk("lw_rvalid", {31'b0, mem_rvalid}, 1);
    chk("lw_rdata", mem_rdata, 32'hCAFE_F00D);
    chk("lw_bk", {31'b0, lsu_bk}, 0);
    // reset while waiting for read data
    issue(0, 2'b10, 0, 32'h8, 0, 5'd2);
    dc_ready = 1;
    cyc();
    dc_ready = 0;
    chk("rw_bk_wait", {31'b0, lsu_bk}, 1);
    rst_n = 0;
    #1;
    chk("rw_req", {31'b0, dc_req}, 0);
    chk("rw_bk", {31'b0, lsu_bk}, 0);
    chk("rw_be", {28'b0, dc_be}, 0);
    rst_n = 1;
    cyc();
    dc_rvalid = 1; dc_rdata = 32'h5555_5555;
    cyc();
    dc_rvalid = 0;
    chk("rw_no_rvalid1", {31'b0, mem_rvalid}, 0);
    cyc();
    chk("rw_no_rvalid2", {31'b0, mem_rvalid}, 0);
    // misaligned word load
    issue(0, 2'b10, 0, 32'h1002, 0, 5'd4);
`ifdef LSU_MISALIGN_EXC_EN
    chk("mis_req", {31'b0, dc_req}, 0);
    chk("mis_rvalid", {31'b0, mem_rvalid}, 1);
    chk("mis_flag", {31'b0, mem_misalign}, 1);
    chk("mis_regwe", {31'b0, mem_reg_we}, 0);
    chk("mis_rdata", mem_rdata, 0);
    chk("mis_bk", {31'b0, lsu_bk}, 0);
    cyc();
    chk("mis_pulse_end", {31'b0, mem_misalign}, 0);
`else
    chk("mis_addr", dc_addr, 32'h1000);
    chk("mis_be", {28'b0, dc_be}, 4'b1111);
    chk("mis_req", {31'b0, dc_req}, 1);
    dc_ready = 1; dc_rvalid = 1; dc_rdata = 32'h1122_3344;
    cyc();
    dc_ready = 0; dc_rvalid = 0;
    chk("mis_rdata", mem_rdata, 32'h1122_3344);
    chk("mis_flag", {31'b0, mem_misalign}, 0);
    chk("mis_rvalid", {31'b0, mem_rvalid}, 1);
`endif
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
